// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and decimal-range helper for the BCD converter
package bcd_pkg;
  localparam int BCD_NIBBLE = 4;
  localparam logic [3:0] BCD_SAT_NIBBLE = 4'h9;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  function automatic int max_decimal(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit corrector, adds 3 to any digit of 5 or more
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = din >= 4'd5 ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter with saturation on overflow
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [WIDTH-1:0]             i_bin,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [BCD_NIBBLE*DIGITS-1:0] o_bcd,
  output logic                         o_overflow
);
  localparam int BW = BCD_NIBBLE * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX_DEC = 32'(max_decimal(DIGITS));
  state_t           state;
  logic [BW-1:0]    scratch, corr;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0]    cnt;
  logic             ovf;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (scratch[d*BCD_NIBBLE +: BCD_NIBBLE]),
      .dout (corr[d*BCD_NIBBLE +: BCD_NIBBLE])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
      scratch    <= '0;
      bin        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          o_busy <= i_start;
          if (i_start) begin
            bin     <= i_bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            ovf     <= 32'(i_bin) > MAX_DEC;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= BW'({corr, bin[WIDTH-1]});
          bin     <= bin << 1;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          o_bcd      <= ovf ? {DIGITS{BCD_SAT_NIBBLE}} : scratch;
          o_overflow <= ovf;
          o_done     <= 1'b1;
          o_busy     <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and random checks of the BCD converter against an arithmetic model
module tb_bin_to_bcd_seq;
  logic        i_clk = 1'b0;
  logic        i_reset, i_start, o_busy, o_done, o_overflow;
  logic [13:0] i_bin;
  logic [15:0] o_bcd;
  int          pass = 0, total = 0;

  bin_to_bcd_seq dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_bin      (i_bin),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_bcd      (o_bcd),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return 16'((v / 1000 % 10) << 12 | (v / 100 % 10) << 8 | (v / 10 % 10) << 4 | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_conv(input int v);
    int k;
    bit stable;
    logic [15:0] prev;
    prev   = o_bcd;
    stable = 1;
    i_bin   = v[13:0];
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_bin   = 14'($urandom);
    chk("busy_after_accept", o_busy, 1);
    k = 0;
    while (o_done !== 1'b1 && k < 40) begin
      if (o_bcd !== prev || o_busy !== 1'b1) stable = 0;
      tick();
      k++;
    end
    chk($sformatf("latency_%0d", v), k, 15);
    chk("held_while_busy", stable, 1);
    chk($sformatf("bcd_%0d", v), o_bcd, ref_bcd(v));
    chk($sformatf("ovf_%0d", v), o_overflow, v > 9999);
    tick();
    chk("done_one_cycle", o_done, 0);
    chk("idle_not_busy", o_busy, 0);
  endtask

  initial begin
    int k, n, t0, t1;
    logic [15:0] r0, r1;
    logic o0, o1;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_bin   = '0;
    tick();
    tick();
    i_reset = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_bcd", o_bcd, 0);
    chk("rst_ovf", o_overflow, 0);
    tick();

    run_conv(1234);

    i_start = 1'b1;
    i_bin   = 14'd0;
    tick();
    i_bin = 14'd9999;
    n = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0; o0 = 1'b0; o1 = 1'b0;
    for (k = 1; k < 40; k++) begin
      tick();
      if (k == 16) i_start = 1'b0;
      if (o_done === 1'b1) begin
        if (n == 0) begin t0 = k; r0 = o_bcd; o0 = o_overflow; end
        else begin t1 = k; r1 = o_bcd; o1 = o_overflow; end
        n++;
      end
    end
    chk("b2b_count", n, 2);
    chk("b2b_first_latency", t0, 15);
    chk("b2b_spacing", t1 - t0, 16);
    chk("b2b_bcd0", r0, ref_bcd(0));
    chk("b2b_bcd1", r1, ref_bcd(9999));
    chk("b2b_ovf0", o0, 0);
    chk("b2b_ovf1", o1, 0);

    run_conv(10000);
    run_conv(42);

    i_bin   = 14'd5678;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0; t0 = -1;
    for (k = 1; k < 40; k++) begin
      if (k == 5) begin i_start = 1'b1; i_bin = 14'd1111; end
      if (k == 6) i_start = 1'b0;
      if (k < 15 && o_bcd !== ref_bcd(42)) t0 = k;
      tick();
      if (o_done === 1'b1) begin
        n++;
        if (n == 1) r0 = o_bcd;
      end
    end
    chk("ignore_done_count", n, 1);
    chk("ignore_bcd", r0, ref_bcd(5678));
    chk("ignore_held", t0, -1);

    i_bin   = 14'd4321;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (k = 1; k < 7; k++) tick();
    i_reset = 1'b1;
    i_start = 1'b1;
    tick();
    i_reset = 1'b0;
    i_start = 1'b0;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_bcd", o_bcd, 0);
    chk("midrst_done", o_done, 0);
    n = 0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (o_done === 1'b1 || o_busy === 1'b1) n++;
    end
    chk("midrst_quiet", n, 0);
    run_conv(8);

    run_conv(9999);
    run_conv(16383);
    for (int i = 0; i < 30; i++) run_conv(int'($urandom_range(0, 16383)));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
